text_buffer: RTL and testbench

- Character store that sits directly upstream of the pixel encoder.
- Holds a 7-row x 20-column grid of 8-bit character codes. The encoder reads the grid by (rin, cin) and gets the code back on charout.
- Accepts a byte stream from the input front-end (UART/keyboard decoder) over a valid/ready handshake.
- Maintains a cursor and implements printable write, backspace, newline, clear-screen and scroll-up.

---
 rtl/text_buffer_pkg.sv | 27 ++
 rtl/text_buffer_if.sv | 11 +
 rtl/text_buffer_ram.sv | 25 ++
 rtl/text_buffer.sv | 174 +++++++++++++++++
 tb/tb_text_buffer.sv | 394 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/text_buffer_pkg.sv
// Shared constants, control codes and state encoding for the text buffer.
// The grid is stored row-major: linear index = row*COLS + col.
package text_buffer_pkg;
    localparam int ROWS  = 7;
    localparam int COLS  = 20;
    localparam int CELLS = ROWS * COLS;

    localparam logic [7:0] BLANK = 8'h20;
    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    localparam logic [7:0] LAST_CELL     = 8'(CELLS - 1);
    localparam logic [7:0] SCROLL_LAST   = 8'(CELLS - COLS - 1);
    localparam logic [7:0] LAST_ROW_BASE = 8'(CELLS - COLS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLEAR   = 2'd1,
        SCROLL  = 2'd2,
        CLR_ROW = 2'd3
    } state_t;

    function automatic logic [7:0] cell_idx(input logic [2:0] row, input logic [4:0] col);
        return 8'(row) * 8'(COLS) + 8'(col);
    endfunction
endpackage

// File: rtl/text_buffer_if.sv
// Byte-stream input from the front-end decoder into the text buffer.
// Handshake: a byte transfers on a rising clk edge where wr_valid && wr_ready;
// wr_data is only meaningful in that cycle, and the master may hold wr_valid high.
interface text_buffer_if;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;

    modport master (output wr_valid, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/text_buffer_ram.sv
// CELLS x 8 character memory: one synchronous write port and two asynchronous
// read ports (A: display lookup, B: scroll source one row below the write pointer).
module text_ram
    import text_buffer_pkg::*;
(
    input  logic       clk,
    input  logic       i_we,
    input  logic [7:0] i_waddr,
    input  logic [7:0] i_wdata,
    input  logic [7:0] i_addr_a,
    output logic [7:0] o_data_a,
    input  logic [7:0] i_addr_b,
    output logic [7:0] o_data_b
);
    logic [7:0] r_mem [CELLS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_data_a = r_mem[i_addr_a];
    assign o_data_b = r_mem[i_addr_b];
endmodule

// File: rtl/text_buffer.sv
// 7x20 character store with cursor control: printable write, backspace, newline,
// clear-screen and scroll-up, plus a zero-latency display read port.
module text_buffer
    import text_buffer_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    text_buffer_if.slave bus,
    input  logic [3:0]   rin,
    input  logic [5:0]   cin,
    output logic [7:0]   charout,
    output logic [2:0]   cur_row,
    output logic [4:0]   cur_col,
    output logic         busy,
    output state_t       o_state
);
    state_t     r_state;
    logic [7:0] r_ptr;
    logic [2:0] r_row;
    logic [4:0] r_col;

    logic       w_accept;
    logic       w_printable;
    logic [7:0] w_cur_idx;
    logic       w_in_range;
    logic [7:0] w_addr_a;
    logic [7:0] w_addr_b;
    logic [7:0] w_rd_a;
    logic [7:0] w_rd_b;
    logic       w_we;
    logic [7:0] w_waddr;
    logic [7:0] w_wdata;

    assign bus.wr_ready = (r_state == IDLE) && !reset;
    assign busy         = (r_state != IDLE) || reset;
    assign w_accept     = bus.wr_valid && bus.wr_ready;
    assign w_printable  = (bus.wr_data >= 8'h20) && (bus.wr_data <= 8'h7E);
    assign w_cur_idx    = cell_idx(r_row, r_col);

    assign cur_row = r_row;
    assign cur_col = r_col;
    assign o_state = r_state;

    // Out-of-grid display coordinates read as blank rather than aliasing into the RAM.
    assign w_in_range = (rin < 4'(ROWS)) && (cin < 6'(COLS));
    assign w_addr_a   = w_in_range ? cell_idx(rin[2:0], cin[4:0]) : 8'd0;
    assign charout    = w_in_range ? w_rd_a : BLANK;
    assign w_addr_b   = (r_state == SCROLL) ? (r_ptr + 8'(COLS)) : 8'd0;

    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_ptr;
        w_wdata = BLANK;
        if (!reset) begin
            case (r_state)
                CLEAR, CLR_ROW: w_we = 1'b1;
                SCROLL: begin
                    w_we    = 1'b1;
                    w_wdata = w_rd_b;
                end
                IDLE: begin
                    if (w_accept) begin
                        if (w_printable) begin
                            w_we    = 1'b1;
                            w_waddr = w_cur_idx;
                            w_wdata = bus.wr_data;
                        end else if (bus.wr_data == CH_BS) begin
                            if (r_col != 5'd0) begin
                                w_we    = 1'b1;
                                w_waddr = w_cur_idx - 8'd1;
                            end else if (r_row != 3'd0) begin
                                w_we    = 1'b1;
                                w_waddr = cell_idx(r_row - 3'd1, 5'(COLS - 1));
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= CLEAR;
            r_ptr   <= 8'd0;
            r_row   <= 3'd0;
            r_col   <= 5'd0;
        end else begin
            case (r_state)
                CLEAR: begin
                    if (r_ptr == LAST_CELL) begin
                        r_state <= IDLE;
                        r_ptr   <= 8'd0;
                        r_row   <= 3'd0;
                        r_col   <= 5'd0;
                    end else begin
                        r_ptr <= r_ptr + 8'd1;
                    end
                end
                SCROLL: begin
                    if (r_ptr == SCROLL_LAST) begin
                        r_state <= CLR_ROW;
                        r_ptr   <= LAST_ROW_BASE;
                    end else begin
                        r_ptr <= r_ptr + 8'd1;
                    end
                end
                CLR_ROW: begin
                    if (r_ptr == LAST_CELL) begin
                        r_state <= IDLE;
                        r_ptr   <= 8'd0;
                    end else begin
                        r_ptr <= r_ptr + 8'd1;
                    end
                end
                IDLE: begin
                    if (w_accept) begin
                        if (w_printable) begin
                            if (r_col < 5'(COLS - 1)) begin
                                r_col <= r_col + 5'd1;
                            end else begin
                                r_col <= 5'd0;
                                if (r_row < 3'(ROWS - 1)) begin
                                    r_row <= r_row + 3'd1;
                                end else begin
                                    r_state <= SCROLL;
                                    r_ptr   <= 8'd0;
                                end
                            end
                        end else begin
                            case (bus.wr_data)
                                CH_CR: begin
                                    r_col <= 5'd0;
                                    if (r_row < 3'(ROWS - 1)) begin
                                        r_row <= r_row + 3'd1;
                                    end else begin
                                        r_state <= SCROLL;
                                        r_ptr   <= 8'd0;
                                    end
                                end
                                CH_BS: begin
                                    if (r_col != 5'd0) begin
                                        r_col <= r_col - 5'd1;
                                    end else if (r_row != 3'd0) begin
                                        r_row <= r_row - 3'd1;
                                        r_col <= 5'(COLS - 1);
                                    end
                                end
                                CH_FF: begin
                                    r_state <= CLEAR;
                                    r_ptr   <= 8'd0;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                default: r_state <= CLEAR;
            endcase
        end
    end

    text_ram u_ram (
        .clk      (clk),
        .i_we     (w_we),
        .i_waddr  (w_waddr),
        .i_wdata  (w_wdata),
        .i_addr_a (w_addr_a),
        .o_data_a (w_rd_a),
        .i_addr_b (w_addr_b),
        .o_data_b (w_rd_b)
    );
endmodule

// File: tb/tb_text_buffer.sv
// Self-checking bench for text_buffer: a grid/cursor reference model kept as a plain
// array, fed by directed and randomized byte streams.
module tb_text_buffer;
    import text_buffer_pkg::*;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] rin   = 4'd0;
    logic [5:0] cin   = 6'd0;
    wire  [7:0] charout;
    wire  [2:0] cur_row;
    wire  [4:0] cur_col;
    wire        busy;
    state_t     dbg_state;

    text_buffer_if bus();

    text_buffer dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .rin     (rin),
        .cin     (cin),
        .charout (charout),
        .cur_row (cur_row),
        .cur_col (cur_col),
        .busy    (busy),
        .o_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] m_mem [140];
    int         m_row;
    int         m_col;
    bit         m_multi;
    logic [7:0] dut_grid [140];

    // ---------------- reference model ----------------
    task automatic model_clear();
        for (int i = 0; i < 140; i++) m_mem[i] = 8'h20;
        m_row = 0;
        m_col = 0;
    endtask

    task automatic model_scroll();
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 20; c++) m_mem[r*20+c] = m_mem[(r+1)*20+c];
        for (int c = 0; c < 20; c++) m_mem[120+c] = 8'h20;
    endtask

    task automatic model_apply(input logic [7:0] b);
        m_multi = 1'b0;
        if (b >= 8'h20 && b <= 8'h7E) begin
            m_mem[m_row*20+m_col] = b;
            if (m_col < 19) m_col++;
            else begin
                m_col = 0;
                if (m_row < 6) m_row++;
                else begin model_scroll(); m_multi = 1'b1; end
            end
        end else if (b == 8'h0D) begin
            m_col = 0;
            if (m_row < 6) m_row++;
            else begin model_scroll(); m_multi = 1'b1; end
        end else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                m_mem[m_row*20+m_col] = 8'h20;
            end else if (m_row > 0) begin
                m_row--;
                m_col = 19;
                m_mem[m_row*20+m_col] = 8'h20;
            end
        end else if (b == 8'h0C) begin
            model_clear();
            m_multi = 1'b1;
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drive(input logic [7:0] b, input bit must_ready);
        int waited;
        waited = 0;
        @(negedge clk);
        while (bus.wr_ready !== 1'b1 && waited < 400) begin
            waited++;
            @(negedge clk);
        end
        if (bus.wr_ready !== 1'b1) begin
            n_cmp++; n_err++;
            $display("FAIL drive_timeout byte %h: wr_ready=%b after %0d cycles, want 1", b, bus.wr_ready, waited);
        end else begin
            if (must_ready) begin
                n_cmp++;
                if (waited != 0) begin
                    n_err++;
                    $display("FAIL back_to_back byte %h: waited %0d cycles, want 0", b, waited);
                end
            end
            bus.wr_valid = 1'b1;
            bus.wr_data  = b;
            @(posedge clk);
            #1 bus.wr_valid = 1'b0;
            model_apply(b);
        end
    endtask

    task automatic wait_idle(input bit hold_valid, output int cycles);
        cycles = 0;
        if (hold_valid) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 8'h58;
        end
        @(negedge clk);
        while (busy && cycles < 400) begin
            cycles++;
            @(negedge clk);
        end
        bus.wr_valid = 1'b0;
    endtask

    task automatic scan_grid();
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 20; c++) begin
                rin = 4'(r);
                cin = 6'(c);
                #1 dut_grid[r*20+c] = charout;
            end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int cyc;
        logic [3:0] oob_r [3];
        logic [5:0] oob_c [3];
        oob_r[0] = 4'd7;  oob_c[0] = 6'd0;
        oob_r[1] = 4'd0;  oob_c[1] = 6'd20;
        oob_r[2] = 4'd15; oob_c[2] = 6'd63;
        reset = 1'b1;
        bus.wr_valid = 1'b0;
        bus.wr_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.wr_ready !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_hold: ready=%b busy=%b, want 0/1", bus.wr_ready, busy);
        end
        reset = 1'b0;
        wait_idle(1'b0, cyc);
        n_cmp++;
        if (cyc != 140) begin n_err++; $display("FAIL reset_clear_len: %0d cycles, want 140", cyc); end
        n_cmp++;
        if (bus.wr_ready !== 1'b1 || dbg_state !== IDLE) begin
            n_err++;
            $display("FAIL reset_ready: ready=%b state=%0d, want 1/IDLE", bus.wr_ready, dbg_state);
        end
        model_clear();
        scan_grid();
        for (int i = 0; i < 140; i++) begin
            n_cmp++;
            if (dut_grid[i] !== m_mem[i]) begin
                n_err++;
                $display("FAIL reset_grid r%0d c%0d: got %h want %h", i/20, i%20, dut_grid[i], m_mem[i]);
            end
        end
        for (int k = 0; k < 3; k++) begin
            rin = oob_r[k];
            cin = oob_c[k];
            #1 n_cmp++;
            if (charout !== 8'h20) begin
                n_err++;
                $display("FAIL reset_oob rin=%0d cin=%0d: got %h want 20", rin, cin, charout);
            end
        end
        n_cmp++;
        if (cur_row !== 3'd0 || cur_col !== 5'd0) begin
            n_err++;
            $display("FAIL reset_cursor: got (%0d,%0d) want (0,0)", cur_row, cur_col);
        end
    endtask

    task automatic test_printable();
        for (int k = 0; k < 20; k++) drive(8'(8'h41 + k), k > 0);
        scan_grid();
        for (int i = 0; i < 140; i++) begin
            n_cmp++;
            if (dut_grid[i] !== m_mem[i]) begin
                n_err++;
                $display("FAIL printable_grid r%0d c%0d: got %h want %h", i/20, i%20, dut_grid[i], m_mem[i]);
            end
        end
        n_cmp++;
        if (cur_row !== 3'(m_row) || cur_col !== 5'(m_col) || m_row != 1 || m_col != 0) begin
            n_err++;
            $display("FAIL printable_cursor: got (%0d,%0d) want (%0d,%0d)", cur_row, cur_col, m_row, m_col);
        end
    endtask

    task automatic test_backspace();
        drive(8'h08, 1'b0);
        rin = 4'd0;
        cin = 6'd19;
        #1 n_cmp++;
        if (cur_row !== 3'd0 || cur_col !== 5'd19 || charout !== 8'h20) begin
            n_err++;
            $display("FAIL bs_wrap: cursor (%0d,%0d) cell %h, want (0,19) 20", cur_row, cur_col, charout);
        end
        drive(8'h08, 1'b0);
        n_cmp++;
        if (cur_row !== 3'd0 || cur_col !== 5'd18) begin
            n_err++;
            $display("FAIL bs_step: cursor (%0d,%0d), want (0,18)", cur_row, cur_col);
        end
        repeat (18) drive(8'h08, 1'b0);
        drive(8'h08, 1'b0);
        scan_grid();
        for (int i = 0; i < 140; i++) begin
            n_cmp++;
            if (dut_grid[i] !== m_mem[i]) begin
                n_err++;
                $display("FAIL bs_origin_grid r%0d c%0d: got %h want %h", i/20, i%20, dut_grid[i], m_mem[i]);
            end
        end
        n_cmp++;
        if (cur_row !== 3'd0 || cur_col !== 5'd0 || bus.wr_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bs_origin: cursor (%0d,%0d) ready %b, want (0,0) 1", cur_row, cur_col, bus.wr_ready);
        end
    endtask

    task automatic test_scroll();
        int cyc;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 20; c++) drive(8'(8'h30 + r), 1'b0);
        for (int c = 0; c < 19; c++) drive(8'h36, 1'b0);
        drive(8'h0D, 1'b0);
        wait_idle(1'b0, cyc);
        n_cmp++;
        if (cyc != 140 || !m_multi) begin
            n_err++;
            $display("FAIL scroll_len: %0d cycles, want 140", cyc);
        end
        scan_grid();
        for (int i = 0; i < 140; i++) begin
            n_cmp++;
            if (dut_grid[i] !== m_mem[i]) begin
                n_err++;
                $display("FAIL scroll_grid r%0d c%0d: got %h want %h", i/20, i%20, dut_grid[i], m_mem[i]);
            end
        end
        n_cmp++;
        if (cur_row !== 3'd6 || cur_col !== 5'd0) begin
            n_err++;
            $display("FAIL scroll_cursor: got (%0d,%0d) want (6,0)", cur_row, cur_col);
        end
    endtask

    task automatic test_form_feed();
        int cyc;
        drive(8'h0C, 1'b0);
        wait_idle(1'b1, cyc);
        n_cmp++;
        if (cyc != 140) begin n_err++; $display("FAIL ff_len: %0d cycles, want 140", cyc); end
        scan_grid();
        for (int i = 0; i < 140; i++) begin
            n_cmp++;
            if (dut_grid[i] !== m_mem[i]) begin
                n_err++;
                $display("FAIL ff_grid r%0d c%0d: got %h want %h", i/20, i%20, dut_grid[i], m_mem[i]);
            end
        end
        n_cmp++;
        if (cur_row !== 3'd0 || cur_col !== 5'd0) begin
            n_err++;
            $display("FAIL ff_cursor: got (%0d,%0d) want (0,0)", cur_row, cur_col);
        end
    endtask

    task automatic test_reset_mid_scroll();
        int cyc;
        for (int c = 0; c < 20; c++) drive(8'($urandom_range(8'h21, 8'h7E)), 1'b0);
        repeat (5) drive(8'h0D, 1'b0);
        drive(8'h0D, 1'b0);
        repeat (50) @(posedge clk);
        #1 reset = 1'b1;
        n_cmp++;
        if (bus.wr_ready !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_hold: ready=%b busy=%b, want 0/1", bus.wr_ready, busy);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        model_clear();
        wait_idle(1'b0, cyc);
        n_cmp++;
        if (cyc != 140) begin n_err++; $display("FAIL midreset_len: %0d cycles, want 140", cyc); end
        scan_grid();
        for (int i = 0; i < 140; i++) begin
            n_cmp++;
            if (dut_grid[i] !== m_mem[i]) begin
                n_err++;
                $display("FAIL midreset_grid r%0d c%0d: got %h want %h", i/20, i%20, dut_grid[i], m_mem[i]);
            end
        end
        n_cmp++;
        if (cur_row !== 3'd0 || cur_col !== 5'd0) begin
            n_err++;
            $display("FAIL midreset_cursor: got (%0d,%0d) want (0,0)", cur_row, cur_col);
        end
    endtask

    task automatic test_ignored();
        logic [7:0] codes [6];
        codes[0] = 8'h07; codes[1] = 8'h00; codes[2] = 8'h1B;
        codes[3] = 8'h7F; codes[4] = 8'h80; codes[5] = 8'hFF;
        for (int c = 0; c < 7; c++) drive(8'($urandom_range(8'h21, 8'h7E)), 1'b0);
        for (int k = 0; k < 6; k++) begin
            drive(codes[k], k > 0);
            n_cmp++;
            if (cur_row !== 3'(m_row) || cur_col !== 5'(m_col) || busy !== 1'b0) begin
                n_err++;
                $display("FAIL ignored_cursor %h: got (%0d,%0d) busy %b want (%0d,%0d) 0",
                         codes[k], cur_row, cur_col, busy, m_row, m_col);
            end
        end
        scan_grid();
        for (int i = 0; i < 140; i++) begin
            n_cmp++;
            if (dut_grid[i] !== m_mem[i]) begin
                n_err++;
                $display("FAIL ignored_grid r%0d c%0d: got %h want %h", i/20, i%20, dut_grid[i], m_mem[i]);
            end
        end
    endtask

    task automatic test_random();
        int cyc;
        int sel;
        logic [7:0] b;
        for (int n = 0; n < 220; n++) begin
            sel = $urandom_range(0, 11);
            if (sel <= 7)       b = 8'($urandom_range(8'h20, 8'h7E));
            else if (sel == 8)  b = 8'h0D;
            else if (sel <= 10) b = 8'h08;
            else                b = 8'($urandom_range(8'h0E, 8'h1F));
            drive(b, 1'b0);
            if (m_multi) begin
                wait_idle(1'b0, cyc);
                n_cmp++;
                if (cyc != 140) begin n_err++; $display("FAIL random_scroll_len: %0d cycles, want 140", cyc); end
            end
            n_cmp++;
            if (cur_row !== 3'(m_row) || cur_col !== 5'(m_col)) begin
                n_err++;
                $display("FAIL random_cursor byte %h: got (%0d,%0d) want (%0d,%0d)", b, cur_row, cur_col, m_row, m_col);
            end
        end
        scan_grid();
        for (int i = 0; i < 140; i++) begin
            n_cmp++;
            if (dut_grid[i] !== m_mem[i]) begin
                n_err++;
                $display("FAIL random_grid r%0d c%0d: got %h want %h", i/20, i%20, dut_grid[i], m_mem[i]);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_data  = 8'h00;
        model_clear();
        test_reset();
        test_printable();
        test_backspace();
        test_scroll();
        test_form_feed();
        test_reset_mid_scroll();
        test_ignored();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
